// File: rtl/gf_pkg.sv
// Shared code parameters for the RS decoder datapath.
package gf_pkg;
  localparam int N_LEN           = 255;
  localparam int T_LEN           = 8;
  localparam int ROOTS_PER_CYCLE = 4;
endpackage

// File: rtl/rs_err_pos_collect_if.sv
// Handshake and result bundle between the Chien search, the position collector and Forney.
interface rs_err_pos_collect_if #(
  parameter int T_LEN     = gf_pkg::T_LEN,
  parameter int ROOTS     = gf_pkg::ROOTS_PER_CYCLE,
  parameter int POS_WIDTH = $clog2(gf_pkg::N_LEN),
  parameter int CNT_WIDTH = $clog2(gf_pkg::T_LEN + 1)
);
  logic                            start;
  logic [CNT_WIDTH-1:0]            err_loc_degree;
  logic                            bit_pos_vld;
  logic [ROOTS-1:0]                error_bit_pos;
  logic                            busy;
  logic                            done;
  logic [T_LEN-1:0][POS_WIDTH-1:0] err_pos;
  logic [T_LEN-1:0]                err_pos_vld;
  logic [CNT_WIDTH-1:0]            err_num;
  logic                            fail;

  modport master (
    output start, err_loc_degree, bit_pos_vld, error_bit_pos,
    input  busy, done, err_pos, err_pos_vld, err_num, fail
  );

  modport slave (
    input  start, err_loc_degree, bit_pos_vld, error_bit_pos,
    output busy, done, err_pos, err_pos_vld, err_num, fail
  );
endinterface

// File: rtl/rs_err_pos_collect.sv
// Compacts Chien-search root hits into an ascending error-position list and
// flags a decode failure when the hit count disagrees with the locator degree.
module rs_err_pos_collect
  import gf_pkg::*;
#(
  parameter int POS_WIDTH = $clog2(N_LEN),
  parameter int CNT_WIDTH = $clog2(T_LEN + 1),
  parameter int BEATS     = (N_LEN + ROOTS_PER_CYCLE - 1) / ROOTS_PER_CYCLE
) (
  input logic                clk,
  input logic                rst,
  rs_err_pos_collect_if.slave bus
);

  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IDX_W  = (T_LEN > 1) ? $clog2(T_LEN) : 1;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_e;

  state_e                          state_q, state_d;
  logic [BEAT_W-1:0]               beat_q, beat_d;
  logic [CNT_WIDTH-1:0]            deg_q, deg_d;
  logic [CNT_WIDTH-1:0]            num_q, num_d;
  logic                            ovf_q, ovf_d;
  logic                            fail_q, fail_d;
  logic [T_LEN-1:0][POS_WIDTH-1:0] pos_q, pos_d;
  logic [T_LEN-1:0]                vld_q, vld_d;
  int                              candPos;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    deg_d   = deg_q;
    num_d   = num_q;
    ovf_d   = ovf_q;
    fail_d  = fail_q;
    pos_d   = pos_q;
    vld_d   = vld_q;
    candPos = 0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SWEEP;
          beat_d  = '0;
          deg_d   = bus.err_loc_degree;
          num_d   = '0;
          ovf_d   = 1'b0;
          fail_d  = 1'b0;
          pos_d   = '0;
          vld_d   = '0;
        end
      end
      SWEEP: begin
        if (bus.bit_pos_vld) begin
          // Running count doubles as the prefix popcount, so hits land in ascending order.
          for (int i = 0; i < ROOTS_PER_CYCLE; i++) begin
            candPos = int'(beat_q) * ROOTS_PER_CYCLE + i;
            if (bus.error_bit_pos[i] && candPos < N_LEN) begin
              if (num_d < CNT_WIDTH'(T_LEN)) begin
                pos_d[num_d[IDX_W-1:0]] = POS_WIDTH'(candPos);
                vld_d[num_d[IDX_W-1:0]] = 1'b1;
                num_d                   = num_d + 1'b1;
              end else begin
                ovf_d = 1'b1;
              end
            end
          end
          beat_d = beat_q + 1'b1;
          if (beat_q == BEAT_W'(BEATS - 1)) begin
            state_d = DONE;
            fail_d  = ovf_d | (num_d != deg_q);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      deg_q   <= '0;
      num_q   <= '0;
      ovf_q   <= 1'b0;
      fail_q  <= 1'b0;
      pos_q   <= '0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      deg_q   <= deg_d;
      num_q   <= num_d;
      ovf_q   <= ovf_d;
      fail_q  <= fail_d;
      pos_q   <= pos_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.busy        = (state_q == SWEEP);
  assign bus.done        = (state_q == DONE);
  assign bus.err_pos     = pos_q;
  assign bus.err_pos_vld = vld_q;
  assign bus.err_num     = num_q;
  assign bus.fail        = fail_q;

endmodule

// File: tb/tb_rs_err_pos_collect.sv
// Directed and randomized sweeps of rs_err_pos_collect against a flat hit-list model.
module tb_rs_err_pos_collect;
  import gf_pkg::*;

  localparam int PW = $clog2(N_LEN);
  localparam int CW = $clog2(T_LEN + 1);
  localparam int R  = ROOTS_PER_CYCLE;
  localparam int NB = (N_LEN + R - 1) / R;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rs_err_pos_collect_if bus ();

  rs_err_pos_collect dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;
  int donePulses = 0;
  int doneSnap;
  logic [R-1:0] beatBits [NB];

  always @(posedge clk) if (bus.done === 1'b1) donePulses++;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: flatten all in-range hits into one ascending list, keep the first T_LEN.
  function automatic void model(input int deg, output int expNum, output logic expFail,
                                output logic [63:0] expPos, output logic [63:0] expVld);
    int hits[$];
    for (int b = 0; b < NB; b++)
      for (int i = 0; i < R; i++)
        if (beatBits[b][i] && (b * R + i) < N_LEN) hits.push_back(b * R + i);
    expNum  = (hits.size() > T_LEN) ? T_LEN : hits.size();
    expFail = (hits.size() > T_LEN) || (expNum != deg);
    expPos  = '0;
    expVld  = '0;
    for (int k = 0; k < expNum; k++) begin
      expPos[k*PW +: PW] = PW'(hits[k]);
      expVld[k]          = 1'b1;
    end
  endfunction

  function automatic int countHits();
    int n = 0;
    for (int b = 0; b < NB; b++)
      for (int i = 0; i < R; i++)
        if (beatBits[b][i] && (b * R + i) < N_LEN) n++;
    return n;
  endfunction

  task automatic clearBeats();
    for (int b = 0; b < NB; b++) beatBits[b] = '0;
  endtask

  task automatic setPos(input int p);
    beatBits[p / R][p % R] = 1'b1;
  endtask

  task automatic checkResults(input string tag, input int deg);
    int          expNum;
    logic        expFail;
    logic [63:0] expPos, expVld;
    model(deg, expNum, expFail, expPos, expVld);
    checkOutput({tag, "/err_num"}, 64'(bus.err_num), 64'(expNum));
    checkOutput({tag, "/fail"}, 64'(bus.fail), 64'(expFail));
    checkOutput({tag, "/err_pos"}, 64'(bus.err_pos), expPos);
    checkOutput({tag, "/err_pos_vld"}, 64'(bus.err_pos_vld), expVld);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "/busy"}, 64'(bus.busy), 64'(0));
    checkOutput({tag, "/done"}, 64'(bus.done), 64'(0));
    checkOutput({tag, "/fail"}, 64'(bus.fail), 64'(0));
    checkOutput({tag, "/err_num"}, 64'(bus.err_num), 64'(0));
    checkOutput({tag, "/err_pos"}, 64'(bus.err_pos), 64'(0));
    checkOutput({tag, "/err_pos_vld"}, 64'(bus.err_pos_vld), 64'(0));
  endtask

  // One full sweep; stall inserts an idle cycle before every beat, abortAt pulses reset.
  task automatic applyStimulus(input string tag, input int deg, input bit stall,
                               input int midStartAt, input int abortAt);
    @(posedge clk); #1;
    bus.start          = 1'b1;
    bus.err_loc_degree = CW'(deg);
    @(posedge clk); #1;
    bus.start = 1'b0;
    checkOutput({tag, "/busy_start"}, 64'(bus.busy), 64'(1));
    doneSnap = donePulses;
    for (int b = 0; b < NB; b++) begin
      if (stall) begin
        bus.bit_pos_vld = 1'b0;
        @(posedge clk); #1;
      end
      if (b == abortAt) begin
        rst = 1'b1;
        #1;
        checkResetValues({tag, "/abort"});
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      bus.bit_pos_vld   = 1'b1;
      bus.error_bit_pos = beatBits[b];
      bus.start         = (b == midStartAt);
      @(posedge clk); #1;
      bus.bit_pos_vld   = 1'b0;
      bus.error_bit_pos = '0;
      bus.start         = 1'b0;
      if (b == NB - 2) checkOutput({tag, "/done_early"}, 64'(bus.done), 64'(0));
    end
    checkOutput({tag, "/done"}, 64'(bus.done), 64'(1));
    checkOutput({tag, "/busy_done"}, 64'(bus.busy), 64'(0));
    checkResults(tag, deg);
    @(posedge clk); #1;
    checkOutput({tag, "/done_pulses"}, 64'(donePulses - doneSnap), 64'(1));
    checkOutput({tag, "/done_drop"}, 64'(bus.done), 64'(0));
    checkResults({tag, "/hold"}, deg);
  endtask

  initial begin
    int deg, n;
    rst                = 1'b1;
    bus.start          = 1'b0;
    bus.err_loc_degree = '0;
    bus.bit_pos_vld    = 1'b0;
    bus.error_bit_pos  = '0;
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("reset");
    rst = 1'b0;

    clearBeats();
    applyStimulus("no_errors", 0, 1'b0, -1, -1);

    clearBeats();
    setPos(1); setPos(40); setPos(43);
    applyStimulus("three_errors", 3, 1'b0, -1, -1);

    clearBeats();
    beatBits[NB-1] = 4'b1000;
    applyStimulus("last_beat_mask", 1, 1'b0, -1, -1);

    clearBeats();
    beatBits[0] = 4'b1111; beatBits[1] = 4'b1111; beatBits[2] = 4'b1111;
    applyStimulus("overflow", 8, 1'b0, -1, -1);

    clearBeats();
    setPos(5); setPos(200);
    applyStimulus("stall_start", 2, 1'b1, 20, -1);

    clearBeats();
    setPos(3); setPos(50); setPos(100);
    applyStimulus("mid_reset", 3, 1'b0, -1, 30);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("mid_reset/no_done", 64'(donePulses - doneSnap), 64'(0));
    checkResetValues("mid_reset/idle");
    applyStimulus("after_reset", 3, 1'b0, -1, -1);

    for (int t = 0; t < 8; t++) begin
      clearBeats();
      for (int b = 0; b < NB; b++)
        if ($urandom_range(0, 15) == 0) beatBits[b] = 4'($urandom_range(1, 15));
      n   = countHits();
      deg = ($urandom_range(0, 1) == 1) ? ((n > T_LEN) ? T_LEN : n) : int'($urandom_range(0, T_LEN));
      applyStimulus($sformatf("random%0d", t), deg, 1'($urandom_range(0, 1)), -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rs_err_pos_collect.md
Name: rs_err_pos_collect

Overview:
- Sits directly downstream of the Chien search stage in the RS decoder.
- Consumes the per-cycle root-hit vector error_bit_pos (ROOTS_PER_CYCLE bits per beat) across a full codeword sweep.
- Compacts the hits into an ordered list of error positions, counts them and checks the count against the error-locator degree.
- Delivers the position list, error count and a decode-fail flag to the Forney/correction stage.

Parameters:
- Uses gf_pkg constants N_LEN (codeword length in symbols), T_LEN (correctable symbols) and ROOTS_PER_CYCLE (roots evaluated per beat).
- POS_WIDTH, default $clog2(N_LEN): width of one error position index.
- CNT_WIDTH, default $clog2(T_LEN+1): width of the error count and locator degree.
- BEATS, default (N_LEN+ROOTS_PER_CYCLE-1)/ROOTS_PER_CYCLE: beats per sweep.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  pulse: begin a new sweep; samples err_loc_degree
- err_loc_degree  in  CNT_WIDTH  degree of the error locator for this codeword
- bit_pos_vld  in  1  error_bit_pos is valid this cycle (one beat)
- error_bit_pos  in  ROOTS_PER_CYCLE  bit i = 1: root found at position beat*ROOTS_PER_CYCLE+i
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse: results valid
- err_pos  out  T_LEN x POS_WIDTH  compacted error positions, ascending
- err_pos_vld  out  T_LEN  per-entry valid
- err_num  out  CNT_WIDTH  number of recorded positions
- fail  out  1  decode failure (count mismatch or overflow)

Behaviour:
- Reset (asynchronous, active-high): state IDLE; busy=0, done=0, fail=0, err_num=0, err_pos all 0, err_pos_vld all 0, beat counter 0.
- FSM states: IDLE, SWEEP, DONE.
- IDLE -> SWEEP on start:
  - clear err_pos, err_pos_vld, err_num, fail, beat counter and overflow flag;
  - latch err_loc_degree into deg_r;
  - busy=1 from the next cycle.
- SWEEP, on each cycle with bit_pos_vld=1:
  - Beat index b = beat counter.
  - Bit i is a candidate only when b*ROOTS_PER_CYCLE+i < N_LEN. Out-of-range bits in the last beat are masked.
  - Candidates are ranked by ascending i (prefix popcount). A candidate of rank r is written to entry err_num+r with value b*ROOTS_PER_CYCLE+i, and err_pos_vld is set for that entry.
  - Any hit whose index would be >= T_LEN is dropped, and the sticky overflow flag is set.
  - err_num increments by the number of written hits and saturates at T_LEN.
  - The beat counter increments.
- bit_pos_vld=0 in SWEEP: hold all state (stall allowed, unlimited length).
- SWEEP -> DONE on the cycle that accepts beat BEATS-1.
- DONE (one cycle), then DONE -> IDLE:
  - done=1, busy=0;
  - fail = overflow OR (err_num != deg_r).
- Outputs err_pos, err_pos_vld, err_num and fail hold until the next start.
- Latency: done is asserted exactly 1 cycle after the final beat is accepted.
- start while busy or in DONE: ignored. bit_pos_vld in IDLE or DONE: ignored.
- start and last-beat acceptance cannot coincide, because start is ignored in SWEEP.
- deg_r=0 with no hits: fail=0, err_num=0. deg_r=0 with any hit: fail=1.
- Reset asserted mid-sweep: immediate return to IDLE with reset values. No done pulse.
- All arithmetic is unsigned. Position computation is POS_WIDTH wide with no wrap, because masked bits are never written.

Test Plan (N_LEN=255, T_LEN=8, ROOTS_PER_CYCLE=4, BEATS=64):
- No errors: start with degree=0, 64 beats of 4'b0000 -> done 1 cycle after beat 63; err_num=0, err_pos_vld=0, fail=0.
- Three errors, degree=3: hits at beat 0 bit 1, beat 10 bits 0 and 3 -> err_pos[0..2]={1,40,43}, err_num=3, fail=0.
- Last-beat mask: degree=1, beat 63 = 4'b1000 (position 255) -> hit dropped; err_num=0, fail=1.
- Overflow: degree=8, beats 0..2 all 4'b1111 (12 hits) -> entries 0..7 = positions 0..7, err_num=8, fail=1.
- Stalls and ignored start: degree=2, hits at positions 5 and 200 with bit_pos_vld toggling 0/1 every cycle, plus start pulsed mid-sweep -> err_pos={5,200}, fail=0, exactly one done pulse.
- Reset mid-sweep: rst pulsed at beat 30 -> all outputs at reset values, no done pulse; a new start then completes normally.
